// File: rtl/game_tick_generator_pkg.sv
// rtl/game_tick_generator_pkg.sv - shared timing defaults for the Tetris tick generator
// Hardware defaults assume a 50 MHz system clock.
package game_tick_generator_pkg;

  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned DEF_LEVEL_W       = 4;
  localparam int unsigned DEF_PIX_DIV       = 2;
  localparam int unsigned DEF_BASE_PERIOD   = 25_000_000;
  localparam int unsigned DEF_LEVEL_STEP    = 2_000_000;
  localparam int unsigned DEF_MIN_PERIOD    = 2_500_000;
  localparam int unsigned DEF_SOFT_SHIFT    = 3;
  localparam int unsigned DEF_REPEAT_PERIOD = 5_000_000;

endpackage

// File: rtl/game_tick_generator_tick_divider.sv
// rtl/game_tick_generator_tick_divider.sv - enable-gated period counter with registered tick
// Priority is clr > hold (en low) > count; the >= compare fires at once if period shrinks mid-count.
module tick_divider
  import game_tick_generator_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period,
  input  logic             en,
  input  logic             clr,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d, term;
  logic             tick_q, tick_d;

  assign term = (period == '0) ? '0 : period - CNT_W'(1);

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_tick_generator.sv
// rtl/game_tick_generator.sv - pixel clock, gravity tick and auto-repeat tick for the game top level
// Ticks are single-cycle enables in the clk_50 domain, not derived clocks.
module game_tick_generator
  import game_tick_generator_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned LEVEL_W       = DEF_LEVEL_W,
  parameter int unsigned PIX_DIV       = DEF_PIX_DIV,
  parameter int unsigned BASE_PERIOD   = DEF_BASE_PERIOD,
  parameter int unsigned LEVEL_STEP    = DEF_LEVEL_STEP,
  parameter int unsigned MIN_PERIOD    = DEF_MIN_PERIOD,
  parameter int unsigned SOFT_SHIFT    = DEF_SOFT_SHIFT,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               pause,
  input  logic               restart,
  input  logic               soft_drop,
  input  logic [LEVEL_W-1:0] level,
  output logic               pix_clk,
  output logic               pix_ce,
  output logic               fall_tick,
  output logic               repeat_tick,
  output logic [CNT_W-1:0]   period_dbg
);

  localparam int unsigned DEC_W  = CNT_W + LEVEL_W;
  localparam int unsigned PCNT_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

  logic [DEC_W-1:0]  dec;
  logic [CNT_W-1:0]  grav_p, shifted, soft_p, period_d, period_q;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              pix_ce_q, pix_ce_d, pix_clk_q, pix_clk_d;
  logic              cnt_en;

  // Saturating subtraction: the wide product is compared before subtracting so it never wraps.
  always_comb begin
    dec = DEC_W'(level) * DEC_W'(LEVEL_STEP);
    if (dec >= DEC_W'(BASE_PERIOD - MIN_PERIOD)) begin
      grav_p = CNT_W'(MIN_PERIOD);
    end else begin
      grav_p = CNT_W'(BASE_PERIOD) - dec[CNT_W-1:0];
    end
    shifted  = grav_p >> SOFT_SHIFT;
    soft_p   = (shifted == '0) ? CNT_W'(1) : shifted;
    period_d = soft_drop ? soft_p : grav_p;
  end

  always_comb begin
    pcnt_d    = (pcnt_q == PCNT_W'(PIX_DIV - 1)) ? '0 : pcnt_q + PCNT_W'(1);
    pix_ce_d  = (pcnt_q == PCNT_W'(PIX_DIV - 1));
    pix_clk_d = (pcnt_q >= PCNT_W'(PIX_DIV / 2));
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      period_q  <= CNT_W'(BASE_PERIOD);
      pcnt_q    <= '0;
      pix_ce_q  <= 1'b0;
      pix_clk_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      pcnt_q    <= pcnt_d;
      pix_ce_q  <= pix_ce_d;
      pix_clk_q <= pix_clk_d;
    end
  end

  assign cnt_en = ~pause;

  tick_divider #(.CNT_W(CNT_W)) u_gravity (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .period (period_q),
    .en     (cnt_en),
    .clr    (restart),
    .tick   (fall_tick)
  );

  tick_divider #(.CNT_W(CNT_W)) u_repeat (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .period (CNT_W'(REPEAT_PERIOD)),
    .en     (cnt_en),
    .clr    (1'b0),
    .tick   (repeat_tick)
  );

  assign pix_clk    = pix_clk_q;
  assign pix_ce     = pix_ce_q;
  assign period_dbg = period_q;

endmodule

// File: tb/tb_game_tick_generator.sv
// tb/tb_game_tick_generator.sv - self-checking bench for game_tick_generator
module tb_game_tick_generator;

  localparam int BASE = 20, STEP = 4, MINP = 4, SHIFT = 2, REP = 6, PDIV = 2;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0, restart = 1'b0, soft_drop = 1'b0;
  logic [3:0]  level = 4'd0;
  logic        pix_clk, pix_ce, fall_tick, repeat_tick;
  logic [31:0] period_dbg;

  int vec_cnt = 0, mis_cnt = 0;
  bit chk_en = 1'b0;

  game_tick_generator #(
    .CNT_W(32), .LEVEL_W(4), .PIX_DIV(PDIV), .BASE_PERIOD(BASE), .LEVEL_STEP(STEP),
    .MIN_PERIOD(MINP), .SOFT_SHIFT(SHIFT), .REPEAT_PERIOD(REP)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .pause(pause), .restart(restart),
    .soft_drop(soft_drop), .level(level), .pix_clk(pix_clk), .pix_ce(pix_ce),
    .fall_tick(fall_tick), .repeat_tick(repeat_tick), .period_dbg(period_dbg)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int calc_period(input int lvl, input bit sd);
    int g;
    g = BASE - lvl * STEP;
    if (g < MINP) g = MINP;
    if (sd) begin
      g = g >> SHIFT;
      if (g < 1) g = 1;
    end
    return g;
  endfunction

  // Model: edges since reset, enabled cycles elapsed since last tick/clear, tick on the period-th one.
  int cyc, m_period, m_gel, m_rel;
  bit m_ft, m_rt;

  always @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0; m_period <= BASE; m_gel <= 0; m_rel <= 0; m_ft <= 1'b0; m_rt <= 1'b0;
    end else begin
      cyc      <= cyc + 1;
      m_period <= calc_period(int'(level), soft_drop);
      if (restart) begin
        m_gel <= 0; m_ft <= 1'b0;
      end else if (pause) begin
        m_ft <= 1'b0;
      end else if (m_gel + 1 >= m_period) begin
        m_gel <= 0; m_ft <= 1'b1;
      end else begin
        m_gel <= m_gel + 1; m_ft <= 1'b0;
      end
      if (pause) begin
        m_rt <= 1'b0;
      end else if (m_rel + 1 >= REP) begin
        m_rel <= 0; m_rt <= 1'b1;
      end else begin
        m_rel <= m_rel + 1; m_rt <= 1'b0;
      end
    end
  end

  always @(negedge clk_50) begin
    if (chk_en) begin
      check("pix_ce",      pix_ce,      (cyc >= 1) && ((cyc - 1) % PDIV == PDIV - 1));
      check("pix_clk",     pix_clk,     (cyc >= 1) && ((cyc - 1) % PDIV >= PDIV / 2));
      check("fall_tick",   fall_tick,   m_ft);
      check("repeat_tick", repeat_tick, m_rt);
      check("period_dbg",  period_dbg,  m_period);
    end
  end

  task automatic wait_fall(input int maxc, output int e);
    e = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_50);
      if (fall_tick) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) begin
      vec_cnt++; mis_cnt++;
      $display("FAIL wait_fall: no fall_tick within %0d cycles", maxc);
    end
  endtask

  task automatic wait_rep(input int maxc, output int e);
    e = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_50);
      if (repeat_tick) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) begin
      vec_cnt++; mis_cnt++;
      $display("FAIL wait_rep: no repeat_tick within %0d cycles", maxc);
    end
  endtask

  task automatic interval(input string name, input int want);
    int a, b;
    wait_fall(40, a);
    wait_fall(40, b);
    check(name, b - a, want);
  endtask

  initial begin
    int e, e2, base_e, rel, hits;
    repeat (3) @(negedge clk_50);
    chk_en = 1'b1;
    check("rst_pix_ce", pix_ce, 0);
    check("rst_pix_clk", pix_clk, 0);
    check("rst_fall", fall_tick, 0);
    check("rst_repeat", repeat_tick, 0);
    check("rst_period", period_dbg, 20);
    reset_n = 1'b1;

    // Level 0 after reset: repeat at edge 6, gravity at edges 20 and 40.
    wait_rep(20, e);  check("first_repeat_edge", e, 6);
    wait_fall(30, e); check("first_fall_edge", e, 20);
    wait_fall(30, e); check("second_fall_edge", e, 40);

    level = 4'd3;
    repeat (2) @(negedge clk_50);
    check("period_lvl3", period_dbg, 8);
    interval("interval_lvl3", 8);
    level = 4'd5;
    repeat (2) @(negedge clk_50);
    check("period_lvl5", period_dbg, 4);
    interval("interval_lvl5", 4);
    level = 4'd15;
    repeat (2) @(negedge clk_50);
    check("period_lvl15", period_dbg, 4);
    interval("interval_lvl15", 4);

    level = 4'd0; soft_drop = 1'b1;
    repeat (2) @(negedge clk_50);
    check("period_soft0", period_dbg, 5);
    interval("interval_soft0", 5);
    level = 4'd15;
    repeat (2) @(negedge clk_50);
    check("period_soft15", period_dbg, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_50);
      check("fall_every_cycle", fall_tick, 1);
    end
    level = 4'd0; soft_drop = 1'b0;

    // Pause at gcnt=10 for 50 cycles.
    wait_fall(60, base_e);
    repeat (10) @(negedge clk_50);
    pause = 1'b1;
    hits = 0;
    repeat (50) begin
      @(negedge clk_50);
      if (fall_tick || repeat_tick) hits++;
    end
    check("ticks_while_paused", hits, 0);
    pause = 1'b0;
    rel = cyc;
    wait_fall(40, e); check("fall_after_resume", e - rel, 10);

    // Restart while a tick is due.
    wait_fall(40, base_e);
    repeat (19) @(negedge clk_50);
    restart = 1'b1;
    @(negedge clk_50);
    restart = 1'b0;
    check("restart_no_tick", fall_tick, 0);
    wait_fall(40, e); check("fall_after_restart", e - base_e, 40);

    // Restart beats pause.
    wait_fall(40, base_e);
    repeat (5) @(negedge clk_50);
    restart = 1'b1; pause = 1'b1;
    @(negedge clk_50);
    restart = 1'b0;
    repeat (3) @(negedge clk_50);
    pause = 1'b0;
    rel = cyc;
    wait_fall(40, e); check("restart_with_pause", e - rel, 20);

    // Level 0->2 at gcnt=15: period shrinks below count.
    wait_fall(40, base_e);
    repeat (15) @(negedge clk_50);
    level = 4'd2;
    wait_fall(40, e);  check("shrink_fire", e - base_e, 17);
    wait_fall(40, e2); check("shrink_interval", e2 - e, 12);

    // Asynchronous reset mid-count.
    level = 4'd0;
    repeat (7) @(negedge clk_50);
    #3 reset_n = 1'b0;
    #1;
    check("async_pix_ce", pix_ce, 0);
    check("async_pix_clk", pix_clk, 0);
    check("async_fall", fall_tick, 0);
    check("async_repeat", repeat_tick, 0);
    check("async_period", period_dbg, 20);
    repeat (2) @(negedge clk_50);
    reset_n = 1'b1;
    wait_fall(40, e); check("fall_after_reset", e, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
